// File: rtl/jbcd_pkg.sv
// Shared types and constants for the digit-serial BCD subtractor.
package jbcd_pkg;
  typedef enum logic [1:0] {IDLE, SUB, COMP, DONE} jbcd_state_e;

  localparam int unsigned       BCD_W     = 4;
  localparam logic [3:0]        BCD_MAX   = 4'd9;
  localparam logic signed [4:0] BCD_RADIX = 5'sd10;
endpackage

// File: rtl/jbcd_digit_sub.sv
// Combinational single BCD digit subtract: d = x - y - bin, borrowing from the next digit.
module jbcd_digit_sub
  import jbcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);
  logic signed [4:0] t;
  logic signed [4:0] adj;

  // Valid digits keep t within -10..9, so 5 signed bits never overflow.
  always_comb begin
    t    = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'b0, bin});
    adj  = t + BCD_RADIX;
    bout = t[4];
    d    = t[4] ? adj[3:0] : t[3:0];
  end
endmodule

// File: rtl/jbcd_serial_sub.sv
// Digit-serial BCD subtractor A - B, LSD first, start/busy/done handshake.
// Define BCD_SIGNMAG_EN to add a complement pass returning negative results as sign-magnitude.
module jbcd_serial_sub
  import jbcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*DIGITS-1:0]     a,
  input  logic [4*DIGITS-1:0]     b,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     diff,
  output logic                    borrow_out,
  output logic                    neg,
  output logic                    err
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  jbcd_state_e   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          brw_q, brw_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic          bout_q, bout_d, neg_q, neg_d, err_q, err_d;
  logic          done_q, done_d, busy_q, busy_d;

  logic [3:0]    x_sel, y_sel, d_o;
  logic          bo_o, bad;

  jbcd_digit_sub u_digit (.x(x_sel), .y(y_sel), .bin(brw_q), .d(d_o), .bout(bo_o));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    brw_d   = brw_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    neg_d   = neg_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (a[k*BCD_W +: BCD_W] > BCD_MAX || b[k*BCD_W +: BCD_W] > BCD_MAX) bad = 1'b1;
    end

    // The complement pass reuses the digit unit as 0 - diff_i - borrow.
    x_sel = (state_q == COMP) ? 4'd0 : a_q[int'(idx_q)*BCD_W +: BCD_W];
    y_sel = (state_q == COMP) ? diff_q[int'(idx_q)*BCD_W +: BCD_W]
                              : b_q[int'(idx_q)*BCD_W +: BCD_W];

    case (state_q)
      IDLE: begin
        // busy stays up through the done cycle so a start there is ignored.
        if (done_q) busy_d = 1'b0;
        if (start && !busy_q) begin
          a_d    = a;
          b_d    = b;
          idx_d  = '0;
          brw_d  = 1'b0;
          diff_d = '0;
          bout_d = 1'b0;
          neg_d  = 1'b0;
          err_d  = bad;
          busy_d = 1'b1;
          state_d = bad ? DONE : SUB;
        end
      end
      SUB: begin
        diff_d[int'(idx_q)*BCD_W +: BCD_W] = d_o;
        if (idx_q == LAST) begin
          bout_d  = bo_o;
          state_d = DONE;
`ifdef BCD_SIGNMAG_EN
          if (bo_o) begin
            state_d = COMP;
            idx_d   = '0;
            brw_d   = 1'b0;
          end
`endif
        end else begin
          idx_d = idx_q + 1'b1;
          brw_d = bo_o;
        end
      end
`ifdef BCD_SIGNMAG_EN
      COMP: begin
        diff_d[int'(idx_q)*BCD_W +: BCD_W] = d_o;
        if (idx_q == LAST) begin
          neg_d   = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
          brw_d = bo_o;
        end
      end
`endif
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      brw_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      brw_q   <= brw_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign err        = err_q;
`ifdef BCD_SIGNMAG_EN
  assign neg        = neg_q;
`else
  assign neg        = 1'b0;
`endif
endmodule

// File: tb/tb_jbcd_serial_sub.sv
// Scoreboard bench for jbcd_serial_sub (DIGITS=4); expectations come from a decimal model.
module tb_jbcd_serial_sub;
  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, borrow_out, neg, err;
  logic [W-1:0] diff;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [W-1:0] diff;
    logic         bo;
    logic         ng;
    logic         er;
    int           lat;
  } exp_t;
  exp_t sb[$];

  jbcd_serial_sub #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
    .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [W-1:0] v, output bit inval);
    int r = 0;
    inval = 1'b0;
    for (int k = D - 1; k >= 0; k--) begin
      if (v[k*4 +: 4] > 4'd9) inval = 1'b1;
      r = r * 10 + int'(v[k*4 +: 4]);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int k = 0; k < D; k++) begin
      r[k*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb);
    exp_t e;
    bit ia, ib;
    int x, y, r;
    x = bcd2int(va, ia);
    y = bcd2int(vb, ib);
    e.diff = '0; e.bo = 1'b0; e.ng = 1'b0; e.er = 1'b0; e.lat = D + 1;
    if (ia || ib) begin
      e.er = 1'b1;
      e.lat = 1;
      return e;
    end
    r = x - y;
    e.bo = (r < 0);
`ifdef BCD_SIGNMAG_EN
    if (r < 0) begin
      e.ng = 1'b1;
      e.diff = int2bcd(-r);
      e.lat = 2 * D + 1;
    end else e.diff = int2bcd(r);
`else
    e.diff = int2bcd((r < 0) ? r + 10000 : r);
`endif
    return e;
  endfunction

  // Caller is at a negedge. Starts an op, optionally re-pulses start at edge 2 with
  // other operands, waits for done, pops the scoreboard and compares. Ends at a negedge.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input bit repulse,
                        input string nm);
    exp_t e;
    int n;
    sb.push_back(model(va, vb));
    a = va; b = vb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got=%b exp=1", nm, busy); end
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (repulse && n == 1) begin
        a = 16'h9999; b = 16'h0001; start = 1'b1;
      end
      if (repulse && n == 2) start = 1'b0;
    end
    e = sb.pop_front();
    total++;
    if (n !== e.lat) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", nm, n, e.lat); end
    total++;
    if (diff !== e.diff) begin bad++; $display("FAIL %s diff got=%h exp=%h", nm, diff, e.diff); end
    total++;
    if (borrow_out !== e.bo) begin bad++; $display("FAIL %s borrow_out got=%b exp=%b", nm, borrow_out, e.bo); end
    total++;
    if (neg !== e.ng) begin bad++; $display("FAIL %s neg got=%b exp=%b", nm, neg, e.ng); end
    total++;
    if (err !== e.er) begin bad++; $display("FAIL %s err got=%b exp=%b", nm, err, e.er); end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== e.diff) begin
      bad++;
      $display("FAIL %s after_done done=%b busy=%b diff=%h exp done=0 busy=0 diff=%h",
               nm, done, busy, diff, e.diff);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, borrow_out, neg, err} !== 5'b0 || diff !== '0) begin
      bad++;
      $display("FAIL reset busy=%b done=%b bo=%b neg=%b err=%b diff=%h exp all 0",
               busy, done, borrow_out, neg, err, diff);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op(16'h5000, 16'h1234, 1'b0, "basic");
    run_op(16'h0009, 16'h0009, 1'b0, "equal");
    run_op(16'h1234, 16'h5000, 1'b0, "negative");
    run_op(16'h0000, 16'h0001, 1'b0, "all_borrow");
    run_op(16'h9999, 16'h0000, 1'b0, "max");
  endtask

  task automatic test_invalid();
    run_op(16'h00A0, 16'h0001, 1'b0, "invalid_a");
    run_op(16'h0001, 16'hF000, 1'b0, "invalid_b");
  endtask

  task automatic test_ignore_start();
    run_op(16'h4321, 16'h1111, 1'b1, "ignore_start");
  endtask

  task automatic test_back_to_back();
    run_op(16'h0500, 16'h0499, 1'b0, "b2b_first");
    run_op(16'h0100, 16'h0200, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 6; i++) begin
      ra = int2bcd(int'($urandom_range(0, 9999)));
      rb = int2bcd(int'($urandom_range(0, 9999)));
      run_op(ra, rb, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    a = 16'h5000; b = 16'h1234; start = 1'b1;
    @(posedge clk);               // edge 0
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst_n = 1'b0; // asserted across edge 3
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, borrow_out, neg, err} !== 5'b0 || diff !== '0) begin
      bad++;
      $display("FAIL reset_mid busy=%b done=%b bo=%b neg=%b err=%b diff=%h exp all 0",
               busy, done, borrow_out, neg, err, diff);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin bad++; $display("FAIL reset_mid_no_done got=1 exp=0"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    run_op(16'h0042, 16'h0017, 1'b0, "after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
